// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS controller:
// FSM state enum, opcode/funct constants, ALU codes and the per-state control word.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       bne;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    // Moore control word for a state; bne only matters in BRANCH, where it
    // selects whether a taken branch needs zero=1 or zero=0.
    function automatic ctrl_t state_ctrl(input state_t s, input logic is_bne);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irwrite = 1'b1;
                c.alusrcb = SRCB_FOUR;
                c.pcsrc   = PCSRC_ALU;
                c.pcwrite = 1'b1;
                c.aluop   = ALUOP_ADD;
            end
            S_DECODE: begin
                c.alusrcb = SRCB_IMMSH;
                c.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_ADD;
            end
            S_MEMRD: c.iord = 1'b1;
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_B;
                c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_B;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = PCSRC_ALUOUT;
                c.branch  = 1'b1;
                c.bne     = is_bne;
            end
            S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_ADD;
            end
            S_ADDIWB: c.regwrite = 1'b1;
            S_JUMP: begin
                c.pcsrc   = PCSRC_JUMP;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the FSM's aluop class and the R-type funct field to an ALU code.
module aludec
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            default: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute per opcode
// and drives registered datapath controls; only pcen mixes in the zero flag.
//
// state     | meaning
// ----------+---------------------------------------------
// FETCH     | read instr at PC into IR, PC <= PC + 4
// DECODE    | read regs, precompute branch target
// MEMADR    | compute lw/sw effective address
// MEMRD     | read data memory at ALUOut
// MEMWB     | write loaded data to rt
// MEMWR     | write B to memory at ALUOut (one cycle)
// EXECUTE   | R-type ALU operation
// ALUWB     | write ALU result to rd
// BRANCH    | compare and conditionally load branch target
// ADDIEX    | rs + sign-extended immediate
// ADDIWB    | write addi result to rt
// JUMP      | load jump target into PC
module main_fsm
    import mips_pkg::*;
#(
    parameter bit SUPPORT_BNE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    ctrl_t  ctrl_out;
    logic   is_bne_d;
    logic   state_legal;

    assign is_bne_d = SUPPORT_BNE && (op == OP_BNE);

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_BNE:       state_d = SUPPORT_BNE ? S_BRANCH : S_FETCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Outputs are registered alongside the state so they are glitch-free Moore values.
    assign ctrl_d = state_ctrl(state_d, is_bne_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH, 1'b0);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // A corrupted state register must not leave stale enables on the datapath.
    assign state_legal = (state_q <= S_JUMP);
    assign ctrl_out    = state_legal ? ctrl_q : '0;

    assign pcen     = ctrl_out.pcwrite | (ctrl_out.branch & (zero ^ ctrl_out.bne));
    assign memwrite = ctrl_out.memwrite;
    assign iord     = ctrl_out.iord;
    assign irwrite  = ctrl_out.irwrite;
    assign regdst   = ctrl_out.regdst;
    assign memtoreg = ctrl_out.memtoreg;
    assign regwrite = ctrl_out.regwrite;
    assign alusrca  = ctrl_out.alusrca;
    assign alusrcb  = ctrl_out.alusrcb;
    assign pcsrc    = ctrl_out.pcsrc;

    aludec u_aludec (
        .funct      (funct),
        .aluop      (ctrl_out.aluop),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed instruction scenarios, async reset
// behaviour and a random instruction stream against a per-instruction cycle model.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    int n_assert = 0;
    int n_fail   = 0;

    main_fsm #(.SUPPORT_BNE(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Vector layout: pcen memwrite iord irwrite regdst memtoreg regwrite alusrca alusrcb pcsrc alucontrol
    function automatic logic [14:0] obs_vec();
        return {pcen, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, alucontrol};
    endfunction

    function automatic logic [2:0] alu_ref(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic int instr_len(input logic [5:0] o);
        case (o)
            6'b100011:                       return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000101, 6'b000010: return 3;
            default:                         return 2;
        endcase
    endfunction

    // What the datapath must see in cycle c (1-based) of instruction o.
    function automatic logic [14:0] model(input logic [5:0] o, input logic [5:0] f,
                                          input logic z, input int c);
        logic pe, mw, io, ir, rd, mtr, rw, asa;
        logic [1:0] asb, ps;
        logic [2:0] ac;
        {pe, mw, io, ir, rd, mtr, rw, asa} = '0;
        asb = 2'b00;
        ps  = 2'b00;
        ac  = 3'b010;
        if (c == 1) begin
            pe = 1'b1; ir = 1'b1; asb = 2'b01;
        end else if (c == 2) begin
            asb = 2'b11;
        end else begin
            case (o)
                6'b100011, 6'b101011: begin
                    if (c == 3) begin
                        asa = 1'b1; asb = 2'b10;
                    end else if (o == 6'b100011 && c == 4) begin
                        io = 1'b1;
                    end else if (o == 6'b100011) begin
                        mtr = 1'b1; rw = 1'b1;
                    end else begin
                        io = 1'b1; mw = 1'b1;
                    end
                end
                6'b000000: begin
                    if (c == 3) begin
                        asa = 1'b1; ac = alu_ref(f);
                    end else begin
                        rd = 1'b1; rw = 1'b1;
                    end
                end
                6'b000100, 6'b000101: begin
                    asa = 1'b1; ac = 3'b110; ps = 2'b01;
                    pe  = z ^ (o == 6'b000101);
                end
                6'b001000: begin
                    if (c == 3) begin
                        asa = 1'b1; asb = 2'b10;
                    end else begin
                        rw = 1'b1;
                    end
                end
                6'b000010: begin
                    ps = 2'b10; pe = 1'b1;
                end
                default: ;
            endcase
        end
        return {pe, mw, io, ir, rd, mtr, rw, asa, asb, ps, ac};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [14:0] exp_v;
        reset = 1'b1; op = 6'b111111; funct = 6'b0; zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        exp_v = model(op, funct, zero, 1);
        n_assert++;
        if (obs_vec() !== exp_v) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", obs_vec(), exp_v);
        end
        reset = 1'b0;
        step();
        #1;
        exp_v = model(op, funct, zero, 2);
        n_assert++;
        if (obs_vec() !== exp_v) begin
            n_fail++;
            $display("FAIL reset_first_edge: got %b expected %b", obs_vec(), exp_v);
        end
        step();
    endtask

    task automatic test_mem();
        logic [5:0]  ops [2] = '{6'b100011, 6'b101011};
        logic [14:0] exp_v;
        for (int k = 0; k < 2; k++) begin
            op = ops[k]; funct = 6'($urandom);
            for (int c = 1; c <= instr_len(op); c++) begin
                zero = 1'($urandom);
                #1;
                exp_v = model(op, funct, zero, c);
                n_assert++;
                if (obs_vec() !== exp_v) begin
                    n_fail++;
                    $display("FAIL mem op=%b cycle %0d: got %b expected %b", op, c, obs_vec(), exp_v);
                end
                step();
            end
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fs [6] = '{6'b101010, 6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b111011};
        logic [14:0] exp_v;
        op = 6'b000000;
        for (int k = 0; k < 6; k++) begin
            funct = fs[k];
            for (int c = 1; c <= 4; c++) begin
                zero = 1'($urandom);
                #1;
                exp_v = model(op, funct, zero, c);
                n_assert++;
                if (obs_vec() !== exp_v) begin
                    n_fail++;
                    $display("FAIL rtype funct=%b cycle %0d: got %b expected %b", funct, c, obs_vec(), exp_v);
                end
                step();
            end
        end
    endtask

    task automatic test_branch();
        logic [14:0] exp_v;
        for (int k = 0; k < 4; k++) begin
            op = (k < 2) ? 6'b000100 : 6'b000101;
            funct = 6'($urandom);
            for (int c = 1; c <= 3; c++) begin
                zero = (c == 3) ? 1'(k % 2) : 1'($urandom);
                #1;
                exp_v = model(op, funct, zero, c);
                n_assert++;
                if (obs_vec() !== exp_v) begin
                    n_fail++;
                    $display("FAIL branch op=%b zero=%b cycle %0d: got %b expected %b", op, zero, c, obs_vec(), exp_v);
                end
                step();
            end
        end
    endtask

    task automatic test_unknown_and_jump();
        logic [5:0]  ops [3] = '{6'b111111, 6'b000010, 6'b001000};
        logic [14:0] exp_v;
        for (int k = 0; k < 3; k++) begin
            op = ops[k]; funct = 6'($urandom);
            for (int c = 1; c <= instr_len(op) + 1; c++) begin
                zero = 1'($urandom);
                #1;
                exp_v = model(op, funct, zero, (c > instr_len(op)) ? 1 : c);
                n_assert++;
                if (obs_vec() !== exp_v) begin
                    n_fail++;
                    $display("FAIL seq op=%b cycle %0d: got %b expected %b", op, c, obs_vec(), exp_v);
                end
                if (c <= instr_len(op)) step();
            end
        end
    endtask

    task automatic test_async_reset();
        logic [14:0] exp_v;
        op = 6'b101011; funct = 6'b0; zero = 1'b0;
        repeat (3) step();
        #1;
        n_assert++;
        if (memwrite !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre_memwr: memwrite got %b expected 1", memwrite);
        end
        clk_run = 1'b0;
        #2 reset = 1'b1;
        #1;
        exp_v = model(op, funct, zero, 1);
        n_assert++;
        if (obs_vec() !== exp_v) begin
            n_fail++;
            $display("FAIL async_reset_no_clk: got %b expected %b", obs_vec(), exp_v);
        end
        #5 reset = 1'b0;
        #5;
        n_assert++;
        if (obs_vec() !== exp_v) begin
            n_fail++;
            $display("FAIL async_release_hold: got %b expected %b", obs_vec(), exp_v);
        end
        clk_run = 1'b1;
        step();
        for (int c = 2; c <= 5; c++) begin
            #1;
            exp_v = model(op, funct, zero, (c == 5) ? 1 : c);
            n_assert++;
            if (obs_vec() !== exp_v) begin
                n_fail++;
                $display("FAIL async_restart cycle %0d: got %b expected %b", c, obs_vec(), exp_v);
            end
            if (c < 5) step();
        end
    endtask

    function automatic bit is_known(input logic [5:0] o);
        return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
    endfunction

    task automatic test_random();
        logic [5:0]  ops [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
        logic [5:0]  fs [5]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [14:0] exp_v;
        int sel;
        for (int n = 0; n < 200; n++) begin
            sel = int'($urandom_range(0, 7));
            if (sel < 7) op = ops[sel];
            else begin
                op = 6'($urandom);
                while (is_known(op)) op = 6'($urandom);
            end
            sel = int'($urandom_range(0, 5));
            funct = (sel < 5) ? fs[sel] : 6'($urandom);
            for (int c = 1; c <= instr_len(op); c++) begin
                zero = 1'($urandom);
                #1;
                exp_v = model(op, funct, zero, c);
                n_assert++;
                if (obs_vec() !== exp_v) begin
                    n_fail++;
                    $display("FAIL random #%0d op=%b funct=%b cycle %0d: got %b expected %b",
                             n, op, funct, c, obs_vec(), exp_v);
                end
                n_assert++;
                if ((memwrite & regwrite) !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random_wr_exclusive #%0d: memwrite=%b regwrite=%b required not both",
                             n, memwrite, regwrite);
                end
                step();
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
        test_reset();
        test_mem();
        test_rtype();
        test_branch();
        test_unknown_and_jump();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
